serial_sub_task: RTL
====================

Name: serial_sub_task

Overview:
- Bit-serial W-bit subtractor with borrow: computes dina - dinb - bin, one bit per clock.
- It is the inverse-direction companion of the combinational comb_task adder (dina + dinb + cin -> sum, cout).
- Operands use the same [0:W-1] ordering: index 0 is MSB, index W-1 is LSB.
- Used wherever area matters more than latency. Start/done handshake; a single requester drives it.

Parameters:
- W, 3: operand and result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while idle
- dina  input  [0:W-1]  minuend; captured on accepted start
- dinb  input  [0:W-1]  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/bout are updated
- diff  output  [0:W-1]  result, (dina - dinb - bin) mod 2^W
- bout  output  1  borrow-out; 1 iff dina < dinb + bin (unsigned)

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - Reset takes priority over all other inputs and aborts any operation in progress; no done is produced for an aborted operation.
- FSM states: IDLE, RUN, FIN.
  - IDLE:
    - If start=1 at an edge: latch dina, dinb and bin; clear counter; go to RUN; busy=1 from the next cycle.
    - If start=0: stay in IDLE.
  - RUN: at each edge, process the bit at index W-1-cnt (LSB first):
    - d = a ^ b ^ brw
    - brw_next = (~a & b) | (~(a ^ b) & brw)
    - shift d into the result register at the matching position, then cnt++.
    - When cnt reaches W-1, this edge processes the MSB; go to FIN.
  - FIN (one cycle):
    - The entering edge loads diff from the result register and bout from the final borrow; done=1 and busy=0 during this cycle.
    - Next edge goes to IDLE, unless start=1, in which case it behaves as an IDLE start-accept directly (back-to-back operation).
- Latency: start sampled at edge k -> done high during the cycle after edge k+W; diff/bout valid from that cycle.
- Throughput: one result per W+1 cycles.
- diff and bout hold their value until the next done or reset; they do not change mid-operation.
- start while busy=1 is ignored, not queued. Operand changes after acceptance have no effect.
- Arithmetic is unsigned modulo 2^W; bin enters as the initial borrow for the LSB.
- Invariant: if the result is fed to comb_task as dina'=diff, dinb'=dinb, cin=bin, the adder reproduces the original dina, with its carry-out equal to bout.

Test Plan:
- Reset, then start with dina=001, dinb=101, bin=0 -> done exactly W=3 cycles after the accept edge; diff=100, bout=1; busy high for 3 cycles.
- dina=010, dinb=111, bin=1 -> diff=010, bout=1. dina=010, dinb=011, bin=1 -> diff=110, bout=1.
- dina=111, dinb=010, bin=0 -> diff=101, bout=0. dina=000, dinb=000, bin=1 -> diff=111, bout=1.
- start held high continuously -> back-to-back results; done every 4 cycles; operands re-captured at each FIN->RUN edge; pulses toggled mid-run ignored.
- rst asserted mid-RUN -> next cycle busy=0, done=0, diff=000, bout=0; no done pulse follows. A subsequent start yields the correct result.
- Exhaustive W=3 sweep (all dina, dinb, bin) -> diff/bout match (dina-dinb-bin) mod 8 and the borrow. Round-trip through the comb_task model returns dina.

Source files
------------

// File: rtl/serial_sub_task.sv
// Bit-serial W-bit subtractor: diff = dina - dinb - bin, one bit per clock, LSB first.
// Operands use [0:W-1] ordering (index 0 is the MSB, index W-1 the LSB).
module serial_sub_task #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [0:W-1] dina,
  input  logic [0:W-1] dinb,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [0:W-1] diff,
  output logic         bout
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e        state_q, state_d;
  logic [0:W-1]  a_q, a_d;
  logic [0:W-1]  b_q, b_d;
  logic [0:W-1]  res_q, res_d;
  logic [0:W-1]  diff_q, diff_d;
  logic          brw_q, brw_d;
  logic          bout_q, bout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic bit_a, bit_b, d_bit, brw_nxt;

  // One full-subtractor cell applied to the current LSB of the shifting operands.
  always_comb begin
    bit_a   = a_q[W-1];
    bit_b   = b_q[W-1];
    d_bit   = bit_a ^ bit_b ^ brw_q;
    brw_nxt = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw_q);
  end

  // Next-state logic; FIN accepts a new start just like IDLE for back-to-back use.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StFin: begin
        if (start) begin
          a_d     = dina;
          b_d     = dinb;
          brw_d   = bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // Operands shift toward the LSB end; result bits enter at the MSB end so that
        // after W shifts the first (LSB) bit sits at index W-1.
        a_d   = {1'b0, a_q[0:W-2]};
        b_d   = {1'b0, b_q[0:W-2]};
        brw_d = brw_nxt;
        res_d = {d_bit, res_q[0:W-2]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // MSB edge: publish the complete result including the bit computed now.
          diff_d  = {d_bit, res_q[0:W-2]};
          bout_d  = brw_nxt;
          cnt_d   = '0;
          state_d = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StFin);
    diff = diff_q;
    bout = bout_q;
  end

endmodule
